// File: rtl/mips_boot_loader.sv
// Byte-stream boot loader: assembles big-endian words from a framed image, writes
// them to instruction memory, and releases core reset once the payload checksum matches.
module mips_boot_loader #(
  parameter int          ADDR_W  = 8,
  parameter int          DEPTH   = 256,
  parameter int          TIMEOUT = 1000000,
  parameter logic [7:0]  MAGIC   = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    WAIT_MAGIC, CNT_HI, CNT_LO, PAYLOAD, WAIT_CHK, DONE
  } state_t;

  localparam int             TW      = $clog2(TIMEOUT + 1);
  localparam logic [16:0]    DEPTH_L = 17'(DEPTH);
  localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT - 1);

  state_t         state;
  logic [7:0]     cnt_hi;
  logic [15:0]    cnt;
  logic [23:0]    word;
  logic [1:0]     byte_idx;
  logic [7:0]     sum;
  logic [TW-1:0]  idle;

  logic           xfer;
  logic [15:0]    cnt_full;
  logic           in_frame;

  assign rx_ready = (state != DONE);
  assign xfer     = rx_valid & rx_ready;
  assign cnt_full = {cnt_hi, rx_data};
  assign in_frame = (state == CNT_HI) || (state == CNT_LO) ||
                    (state == PAYLOAD) || (state == WAIT_CHK);

  // Frame sequencer, word assembly, memory write port and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_MAGIC;
      cnt_hi       <= 8'd0;
      cnt          <= 16'd0;
      word         <= 24'd0;
      byte_idx     <= 2'd0;
      sum          <= 8'd0;
      idle         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        WAIT_MAGIC: begin
          if (xfer && (rx_data == MAGIC)) begin
            state        <= CNT_HI;
            error        <= 1'b0;
            words_loaded <= 16'd0;
            sum          <= 8'd0;
            byte_idx     <= 2'd0;
            imem_addr    <= '0;
          end
        end
        CNT_HI: begin
          if (xfer) begin
            cnt_hi <= rx_data;
            state  <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (xfer) begin
            if ((cnt_full == 16'd0) || ({1'b0, cnt_full} > DEPTH_L)) begin
              error <= 1'b1;
              state <= WAIT_MAGIC;
            end else begin
              cnt   <= cnt_full;
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            sum      <= sum + rx_data;
            word     <= {word[15:0], rx_data};
            byte_idx <= byte_idx + 2'd1;
            // Last byte of a word: write lands on the following cycle.
            if (byte_idx == 2'd3) begin
              imem_we      <= 1'b1;
              imem_wdata   <= {word, rx_data};
              imem_addr    <= words_loaded[ADDR_W-1:0];
              words_loaded <= words_loaded + 16'd1;
              if ((words_loaded + 16'd1) == cnt) begin
                state <= WAIT_CHK;
              end
            end
          end
        end
        WAIT_CHK: begin
          if (xfer) begin
            if (rx_data == sum) begin
              done       <= 1'b1;
              core_reset <= 1'b0;
              state      <= DONE;
            end else begin
              error <= 1'b1;
              state <= WAIT_MAGIC;
            end
          end
        end
        DONE: begin
          if (reload) begin
            done       <= 1'b0;
            core_reset <= 1'b1;
            state      <= WAIT_MAGIC;
          end
        end
        default: state <= WAIT_MAGIC;
      endcase

      // Inter-byte idle watchdog; only reached when no byte moved this cycle.
      if (in_frame && !xfer) begin
        if (idle == T_LAST) begin
          idle  <= '0;
          error <= 1'b1;
          state <= WAIT_MAGIC;
        end else begin
          idle <= idle + 1'b1;
        end
      end else begin
        idle <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Directed bench for mips_boot_loader: frames are sent byte by byte and
// outputs plus a log of memory writes are checked against hand-computed values.
module tb_mips_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;

  int          wr_count = 0;
  logic [7:0]  wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          base;

  mips_boot_loader #(.ADDR_W(8), .DEPTH(256), .TIMEOUT(16), .MAGIC(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_reset(core_reset),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Log every write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (wr_count < 64) begin
        wr_addr[wr_count] = imem_addr;
        wr_data[wr_count] = imem_wdata;
      end
      wr_count = wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; reload = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",    {31'd0, imem_we},    32'd0);
    chk("rst_addr",  {24'd0, imem_addr},  32'd0);
    chk("rst_wdata", imem_wdata,          32'd0);
    chk("rst_core",  {31'd0, core_reset}, 32'd1);
    chk("rst_done",  {31'd0, done},       32'd0);
    chk("rst_err",   {31'd0, error},      32'd0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", {31'd0, rx_ready},   32'd1);

    // Garbage before MAGIC is dropped
    send(8'h00); send(8'hFF); send(8'h12);
    chk("garb_err",   {31'd0, error}, 32'd0);
    chk("garb_wr",    wr_count,       32'd0);

    // Normal two-word load, checksum 0x42
    base = wr_count;
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'hDE); send(8'hAD); send(8'hBE);
    chk("lat_pre_we", {31'd0, imem_we}, 32'd0);
    send(8'hEF);
    chk("lat_we",    {31'd0, imem_we},      32'd1);
    chk("lat_wdata", imem_wdata,            32'hDEADBEEF);
    chk("lat_words", {16'd0, words_loaded}, 32'd1);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h42);
    @(negedge clk);
    chk("n_wrcnt", wr_count - base,          32'd2);
    chk("n_a0",    {24'd0, wr_addr[base]},   32'd0);
    chk("n_d0",    wr_data[base],            32'hDEADBEEF);
    chk("n_a1",    {24'd0, wr_addr[base+1]}, 32'd1);
    chk("n_d1",    wr_data[base+1],          32'h01020304);
    chk("n_done",  {31'd0, done},            32'd1);
    chk("n_core",  {31'd0, core_reset},      32'd0);
    chk("n_words", {16'd0, words_loaded},    32'd2);
    chk("n_ready", {31'd0, rx_ready},        32'd0);
    chk("n_err",   {31'd0, error},           32'd0);

    // Reload then a one-word frame, checksum 0xAA
    pulse_reload();
    chk("rl_core",  {31'd0, core_reset}, 32'd1);
    chk("rl_done",  {31'd0, done},       32'd0);
    chk("rl_ready", {31'd0, rx_ready},   32'd1);
    base = wr_count;
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'hAA);
    @(negedge clk);
    chk("rl_wrcnt", wr_count - base,        32'd1);
    chk("rl_a0",    {24'd0, wr_addr[base]}, 32'd0);
    chk("rl_d0",    wr_data[base],          32'h11223344);
    chk("rl_done2", {31'd0, done},          32'd1);
    chk("rl_words", {16'd0, words_loaded},  32'd1);

    // Bad checksum: words still written, error raised
    pulse_reload();
    base = wr_count;
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h43);
    @(negedge clk);
    chk("bad_wrcnt", wr_count - base,     32'd2);
    chk("bad_err",   {31'd0, error},      32'd1);
    chk("bad_done",  {31'd0, done},       32'd0);
    chk("bad_core",  {31'd0, core_reset}, 32'd1);
    chk("bad_ready", {31'd0, rx_ready},   32'd1);
    send(8'hA5);
    chk("bad_clr",   {31'd0, error},      32'd0);
    send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'hAA);
    chk("bad_retry", {31'd0, done},       32'd1);
    pulse_reload();

    // Length limits: 257 and 0 are rejected
    base = wr_count;
    send(8'hA5); send(8'h01);
    chk("len_mid", {31'd0, error}, 32'd0);
    send(8'h01);
    chk("len_big", {31'd0, error}, 32'd1);
    send(8'hA5); send(8'h00);
    chk("len_clr", {31'd0, error}, 32'd0);
    send(8'h00);
    chk("len_zero", {31'd0, error}, 32'd1);
    @(negedge clk);
    chk("len_wr", wr_count - base, 32'd0);

    // Timeout after 16 idle cycles mid-word
    base = wr_count;
    send(8'hA5); send(8'h00); send(8'h01); send(8'hDE);
    repeat (15) @(posedge clk);
    #1;
    chk("to_15", {31'd0, error}, 32'd0);
    @(posedge clk);
    #1;
    chk("to_16", {31'd0, error}, 32'd1);
    send(8'hAD); send(8'hBE); send(8'hEF);
    @(negedge clk);
    chk("to_wr", wr_count - base, 32'd0);

    // Reset lands on the edge that accepts a word's last byte
    base = wr_count;
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33);
    @(negedge clk);
    rx_data = 8'h44; rx_valid = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("mr_we",    {31'd0, imem_we},       32'd0);
    chk("mr_words", {16'd0, words_loaded},  32'd0);
    chk("mr_core",  {31'd0, core_reset},    32'd1);
    chk("mr_err",   {31'd0, error},         32'd0);
    chk("mr_addr",  {24'd0, imem_addr},     32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("mr_wr", wr_count - base, 32'd0);
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'hCA); send(8'hFE); send(8'hF0); send(8'h0D);
    send(8'hC5);
    @(negedge clk);
    chk("mr_wrcnt", wr_count - base,        32'd1);
    chk("mr_a0",    {24'd0, wr_addr[base]}, 32'd0);
    chk("mr_d0",    wr_data[base],          32'hCAFEF00D);
    chk("mr_done",  {31'd0, done},          32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
